// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle MIPS control unit: state enum,
// opcodes, mux4 select encodings and the decoded control vector.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWR,
    S_MEMWB,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // pcen comes from three sources: unconditional (jump),
  // gated by mem_ready (fetch) or gated by the branch test.
  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       irwrite_mr;
    logic       pcen_mr;
    logic       pcen_br;
    logic       pcen;
    logic       regwrite;
  } ctrl_t;

  function automatic logic is_mem_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) ||
           (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control vector decode.
// Ports: state (in), ctrl (out, ungated control vector).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alusrcb    = SRCB_FOUR;
        ctrl.aluop      = ALU_ADD;
        ctrl.pcsrc      = PC_ALU;
        ctrl.irwrite_mr = 1'b1;
        ctrl.pcen_mr    = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH2;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.mem_req = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_req  = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_SUB;
        ctrl.pcsrc   = PC_ALUOUT;
        ctrl.pcen_br = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc = PC_JUMP;
        ctrl.pcen  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: state register, next-state,
// memory wait timeout and mem_ready/zero gating of enables.
// Ports: clk, rst, opcode, zero, mem_ready in; mux selects,
// mem_req/memwrite, irwrite/pcen/regwrite, illegal_op,
// mem_timeout out. Define MC_CTRL_BNE_EN to support bne.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       illegal_op,
  output logic       mem_timeout
);

  state_t state;
  state_t state_n;
  ctrl_t  c;
  logic   expire;
  logic   br_take;

  mc_ctrl_decode u_decode (
    .state (state),
    .ctrl  (c)
  );

`ifdef MC_CTRL_BNE_EN
  logic [5:0] op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      op_q <= '0;
    else if (state == S_DECODE)
      op_q <= opcode;
  end

  assign br_take = (op_q == OP_BNE) ? ~zero : zero;
`else
  assign br_take = zero;
`endif

  generate
    if (TIMEOUT > 0) begin : g_to
      localparam int CW =
        (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CW-1:0] cnt;

      // mem_ready wins over expiry.
      assign expire = is_mem_wait(state) &&
                      !mem_ready &&
                      (cnt == CW'(TIMEOUT - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt <= '0;
        else if (state_n != state || expire)
          cnt <= '0;
        else if (is_mem_wait(state) && !mem_ready)
          cnt <= cnt + CW'(1);
      end
    end else begin : g_no_to
      assign expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    illegal_op = 1'b0;
    unique case (state)
      S_IDLE:  state_n = S_FETCH;
      S_FETCH: begin
        if (mem_ready)
          state_n = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_EXEC;
          OP_BEQ:       state_n = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_n = S_BRANCH;
`endif
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JUMP;
          default: begin
            state_n    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        state_n = (opcode == OP_SW) ? S_MEMWR
                                    : S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready)
          state_n = S_MEMWB;
      end
      S_MEMWR: begin
        if (mem_ready)
          state_n = S_FETCH;
      end
      S_EXEC:   state_n = S_ALUWB;
      S_ADDIEX: state_n = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH,
      S_ADDIWB, S_JUMP:
        state_n = S_FETCH;
      default:  state_n = S_IDLE;
    endcase
    if (expire)
      state_n = S_FETCH;
  end

  assign mem_req     = c.mem_req;
  assign memwrite    = c.memwrite;
  assign iord        = c.iord;
  assign alusrca     = c.alusrca;
  assign regdst      = c.regdst;
  assign memtoreg    = c.memtoreg;
  assign alusrcb     = c.alusrcb;
  assign pcsrc       = c.pcsrc;
  assign aluop       = c.aluop;
  assign regwrite    = c.regwrite;
  assign irwrite     = c.irwrite_mr & mem_ready;
  assign pcen        = c.pcen |
                       (c.pcen_mr & mem_ready) |
                       (c.pcen_br & br_take);
  assign mem_timeout = expire;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed scenarios plus
// random opcodes/handshakes against an instruction-level model.
module tb_mc_ctrl_fsm;

  localparam int TO = 4;

  localparam int U_IDLE = 0;
  localparam int U_FETCH = 1;
  localparam int U_DEC = 2;
  localparam int U_ADR = 3;
  localparam int U_RD = 4;
  localparam int U_WR = 5;
  localparam int U_LWB = 6;
  localparam int U_EX = 7;
  localparam int U_RWB = 8;
  localparam int U_BR = 9;
  localparam int U_AIX = 10;
  localparam int U_AWB = 11;
  localparam int U_J = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, iord, alusrca;
  logic       regdst, memtoreg;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       irwrite, pcen, regwrite;
  logic       illegal_op, mem_timeout;
  logic [16:0] obs;

  int n_chk = 0;
  int n_fail = 0;

  int cur;
  int wcnt;
  int q[$];
  bit bne_q;

  mc_ctrl_fsm #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .memwrite    (memwrite),
    .iord        (iord),
    .alusrca     (alusrca),
    .regdst      (regdst),
    .memtoreg    (memtoreg),
    .alusrcb     (alusrcb),
    .pcsrc       (pcsrc),
    .aluop       (aluop),
    .irwrite     (irwrite),
    .pcen        (pcen),
    .regwrite    (regwrite),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, memwrite, iord, alusrca,
                regdst, memtoreg, alusrcb, pcsrc,
                aluop, irwrite, pcen, regwrite,
                illegal_op, mem_timeout};

  task automatic check(input string tag,
                       input logic [16:0] o,
                       input logic [16:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, o, e);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    bit ok;
    ok = op inside {6'h00, 6'h23, 6'h2B, 6'h04,
                    6'h08, 6'h02};
`ifdef MC_CTRL_BNE_EN
    if (op == 6'h05) ok = 1'b1;
`endif
    return ok;
  endfunction

  function automatic bit is_mem(input int u);
    return u == U_FETCH || u == U_RD || u == U_WR;
  endfunction

  // Expected bundle from the per-step rules of each
  // instruction phase.
  function automatic logic [16:0] exp_of(
    input int u, input logic [5:0] op,
    input logic mr, input logic z, input bit to);
    logic mq, mw, io, sa, rd, mr2, ir, pc, rw, il;
    logic [1:0] sb, ps, ao;
    {mq, mw, io, sa, rd, mr2, ir, pc, rw, il} = '0;
    sb = 0; ps = 0; ao = 0;
    case (u)
      U_FETCH: begin
        mq = 1; sb = 1; ir = mr; pc = mr;
      end
      U_DEC: begin sb = 3; il = !legal(op); end
      U_ADR: begin sa = 1; sb = 2; end
      U_RD:  begin io = 1; mq = 1; end
      U_WR:  begin io = 1; mq = 1; mw = 1; end
      U_LWB: begin mr2 = 1; rw = 1; end
      U_EX:  begin sa = 1; ao = 2; end
      U_RWB: begin rd = 1; rw = 1; end
      U_BR: begin
        sa = 1; ao = 1; ps = 1;
        pc = bne_q ? !z : z;
      end
      U_AIX: begin sa = 1; sb = 2; end
      U_AWB: rw = 1;
      U_J:   begin ps = 2; pc = 1; end
      default: ;
    endcase
    return {mq, mw, io, sa, rd, mr2, sb, ps, ao,
            ir, pc, rw, il, to};
  endfunction

  function automatic int pop_next();
    if (q.size() > 0) return q.pop_front();
    return U_FETCH;
  endfunction

  task automatic model_reset();
    cur = U_IDLE;
    wcnt = 0;
    q.delete();
    bne_q = 0;
  endtask

  task automatic step(input logic [5:0] op,
                      input logic mr,
                      input logic z);
    bit to;
    @(negedge clk);
    opcode = op;
    mem_ready = mr;
    zero = z;
    #1;
    to = is_mem(cur) && !mr && (wcnt == TO - 1);
    check($sformatf("uop%0d", cur), obs,
          exp_of(cur, op, mr, z, to));
    case (cur)
      U_IDLE: cur = U_FETCH;
      U_FETCH, U_RD, U_WR: begin
        if (mr) begin
          wcnt = 0;
          cur = (cur == U_FETCH) ? U_DEC : pop_next();
        end else if (to) begin
          wcnt = 0;
          q.delete();
          cur = U_FETCH;
        end else begin
          wcnt++;
        end
      end
      U_DEC: begin
        bne_q = (op == 6'h05);
        if (legal(op)) begin
          case (op)
            6'h23: q = '{U_ADR, U_RD, U_LWB};
            6'h2B: q = '{U_ADR, U_WR};
            6'h00: q = '{U_EX, U_RWB};
            6'h08: q = '{U_AIX, U_AWB};
            6'h02: q = '{U_J};
            default: q = '{U_BR};
          endcase
        end
        cur = pop_next();
      end
      default: cur = pop_next();
    endcase
  endtask

  // Runs one instruction from FETCH back to FETCH.
  task automatic instr(input logic [5:0] op,
                       input logic z);
    int g;
    step(op, 1'b1, z);
    g = 0;
    while (cur != U_FETCH && g < 10) begin
      step(op, 1'b1, z);
      g++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", obs, 17'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [9];
    tbl = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
            6'h08, 6'h02, 6'h3F, 6'h00};
    if ($urandom_range(0, 9) == 0)
      return 6'($urandom_range(0, 63));
    return tbl[$urandom_range(0, 8)];
  endfunction

  initial begin
    int g;
    logic [5:0] rop;
    rst = 1'b1;
    opcode = '0;
    zero = 1'b0;
    mem_ready = 1'b0;
    model_reset();
    #1;
    check("reset_async", obs, 17'd0);
    do_reset();

    // R-type: IDLE FETCH DECODE EXEC ALUWB FETCH
    repeat (6) step(6'h00, 1'b1, 1'b0);
    check("rtype_back_fetch", 17'(cur), 17'(U_DEC));

    // lw with MEMRD stalled 3 cycles
    do_reset();
    step(6'h23, 1'b1, 1'b0);
    step(6'h23, 1'b1, 1'b0);
    step(6'h23, 1'b1, 1'b0);
    step(6'h23, 1'b1, 1'b0);
    repeat (3) step(6'h23, 1'b0, 1'b0);
    step(6'h23, 1'b1, 1'b0);
    step(6'h23, 1'b1, 1'b0);

    // branches, jump, addi, sw, illegal
    instr(6'h04, 1'b1);
    instr(6'h04, 1'b0);
    instr(6'h05, 1'b1);
    instr(6'h05, 1'b0);
    instr(6'h02, 1'b0);
    instr(6'h08, 1'b0);
    instr(6'h2B, 1'b0);
    instr(6'h3F, 1'b0);

    // fetch timeout after TO wait cycles
    repeat (TO + 2) step(6'h00, 1'b0, 1'b0);
    instr(6'h00, 1'b0);

    // reset during MEMWR with mem_ready high
    g = 0;
    while (cur != U_WR && g < 20) begin
      step(6'h2B, 1'b1, 1'b0);
      g++;
    end
    check("reach_memwr", 17'(cur), 17'(U_WR));
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("memwrite_hi", 17'(memwrite), 17'd1);
    rst = 1'b1;
    #1;
    check("memwrite_async", 17'(memwrite), 17'd0);
    check("rst_mid_outs", obs, 17'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (3) step(6'h00, 1'b1, 1'b0);

    // random traffic
    rop = 6'h00;
    for (int i = 0; i < 2000; i++) begin
      if (cur == U_FETCH || cur == U_IDLE)
        rop = pick_op();
      step(rop, ($urandom_range(0, 99) < 70),
           1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
